led_fade_driver: RTL and testbench

//  Downstream stage for the gray-code LED pattern generator: takes the raw N-bit on/off

---
 rtl/led_fade_driver.sv | 154 +++++++++++++++
 tb/tb_led_fade_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// led_fade_driver: per-channel PWM dimming with smooth up/down ramps.
// Sits between the gray-code pattern source and the board LED pins.
module led_fade_driver #(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_LEDS-1:0] pattern_in,
    output logic [N_LEDS-1:0] led_out,
    output logic              pwm_wrap,
    output logic              busy
);

    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = '0;
    localparam logic [PWM_BITS-1:0] LVL_NEAR = LVL_MAX - LVL_ONE;

    localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);
    localparam logic [FW-1:0] FADE_ONE  = {{(FW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } chan_state_e;

    logic [N_LEDS-1:0]   pattern_q, pattern_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
    logic                pwm_wrap_q, pwm_wrap_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                fade_tick;
    logic                shadow_load;

    chan_state_e         state_q  [N_LEDS];
    chan_state_e         state_d  [N_LEDS];
    logic [PWM_BITS-1:0] level_q  [N_LEDS];
    logic [PWM_BITS-1:0] level_d  [N_LEDS];
    logic [PWM_BITS-1:0] shadow_q [N_LEDS];
    logic [PWM_BITS-1:0] shadow_d [N_LEDS];

    assign fade_tick   = enable & (fade_cnt_q == FADE_LAST);
    assign shadow_load = enable & (pwm_cnt_q == LVL_MAX);

    // Shared counters and input sampling; everything holds while disabled.
    always_comb begin
        pattern_d  = pattern_q;
        pwm_cnt_d  = pwm_cnt_q;
        fade_cnt_d = fade_cnt_q;
        if (enable) begin
            pattern_d = pattern_in;
            pwm_cnt_d = pwm_cnt_q + LVL_ONE;
            if (fade_cnt_q == FADE_LAST) begin
                fade_cnt_d = '0;
            end else begin
                fade_cnt_d = fade_cnt_q + FADE_ONE;
            end
        end
        pwm_wrap_d = shadow_load;
    end

    // Channel next-state: step one level per fade tick, reversals cost one tick.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            if (fade_tick) begin
                unique case (state_q[i])
                    S_OFF: begin
                        if (pattern_q[i]) state_d[i] = S_UP;
                    end
                    S_UP: begin
                        if (!pattern_q[i]) begin
                            state_d[i] = S_DOWN;
                        end else if (level_q[i] == LVL_MAX) begin
                            state_d[i] = S_ON;
                        end else begin
                            level_d[i] = level_q[i] + LVL_ONE;
                            if (level_q[i] == LVL_NEAR) state_d[i] = S_ON;
                        end
                    end
                    S_ON: begin
                        if (!pattern_q[i]) state_d[i] = S_DOWN;
                    end
                    S_DOWN: begin
                        if (pattern_q[i]) begin
                            state_d[i] = S_UP;
                        end else if (level_q[i] == LVL_ZERO) begin
                            state_d[i] = S_OFF;
                        end else begin
                            level_d[i] = level_q[i] - LVL_ONE;
                            if (level_q[i] == LVL_ONE) state_d[i] = S_OFF;
                        end
                    end
                endcase
            end
        end
    end

    // Shadow latch at period end and PWM compare against the latched duty.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            shadow_d[i] = shadow_load ? level_q[i] : shadow_q[i];
            led_d[i]    = enable & ((shadow_q[i] == LVL_MAX) |
                                    (pwm_cnt_q < shadow_q[i]));
        end
    end

    // Channel outputs: busy while any channel is ramping.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (state_q[i] == S_UP || state_q[i] == S_DOWN) busy = 1'b1;
        end
    end

    // State register for counters, channel FSMs, levels, shadows and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            pwm_wrap_q <= 1'b0;
            led_q      <= '0;
            for (int i = 0; i < N_LEDS; i++) begin
                state_q[i]  <= S_OFF;
                level_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            pattern_q  <= pattern_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            pwm_wrap_q <= pwm_wrap_d;
            led_q      <= led_d;
            for (int i = 0; i < N_LEDS; i++) begin
                state_q[i]  <= state_d[i];
                level_q[i]  <= level_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign led_out  = led_q;
    assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: lockstep reference model with directed and random stimulus.
// Model tracks per-channel level and ramp direction with plain integers.
module tb_led_fade_driver;

    localparam int N   = 8;
    localparam int MAXL = 7;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] pattern_in;
    logic [N-1:0] led_out;
    logic         pwm_wrap;
    logic         busy;

    led_fade_driver #(
        .N_LEDS  (N),
        .PWM_BITS(3),
        .FADE_DIV(DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pattern_in(pattern_in),
        .led_out   (led_out),
        .pwm_wrap  (pwm_wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int         m_lvl [N];
    int         m_dir [N];
    int         m_shd [N];
    int         m_pcnt;
    int         m_fcnt;
    logic [N-1:0] m_pat;
    logic [N-1:0] m_led;
    logic       m_wrap;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic m_busy();
        for (int i = 0; i < N; i++) if (m_dir[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lvl[i] = 0;
            m_dir[i] = 0;
            m_shd[i] = 0;
        end
        m_pcnt = 0;
        m_fcnt = 0;
        m_pat  = '0;
        m_led  = '0;
        m_wrap = 1'b0;
    endtask

    // One clock edge of the reference model, using pre-edge inputs.
    task automatic model_edge(input logic [N-1:0] pin, input logic en);
        int tgt;
        int want;
        logic tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_led  = '0;
            m_wrap = 1'b0;
            return;
        end
        tick = (m_fcnt == DIV - 1);
        for (int i = 0; i < N; i++)
            m_led[i] = (m_shd[i] == MAXL) || (m_pcnt < m_shd[i]);
        m_wrap = (m_pcnt == MAXL);
        if (m_pcnt == MAXL)
            for (int i = 0; i < N; i++) m_shd[i] = m_lvl[i];
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                tgt  = m_pat[i] ? MAXL : 0;
                want = m_pat[i] ? 1 : -1;
                if (m_dir[i] == 0) begin
                    if (m_lvl[i] != tgt) m_dir[i] = want;
                end else if (m_dir[i] != want) begin
                    m_dir[i] = want;
                end else if (m_lvl[i] == tgt) begin
                    m_dir[i] = 0;
                end else begin
                    m_lvl[i] += m_dir[i];
                    if (m_lvl[i] == tgt) m_dir[i] = 0;
                end
            end
        end
        m_pat  = pin;
        m_pcnt = (m_pcnt + 1) % (MAXL + 1);
        m_fcnt = (m_fcnt + 1) % DIV;
    endtask

    task automatic step(input logic [N-1:0] pin, input logic en);
        pattern_in = pin;
        enable     = en;
        @(posedge clk);
        model_edge(pin, en);
        #1;
        check("led_out", {24'b0, led_out}, {24'b0, m_led});
        check("pwm_wrap", {31'b0, pwm_wrap}, {31'b0, m_wrap});
        check("busy", {31'b0, busy}, {31'b0, m_busy()});
    endtask

    initial begin
        int hold;
        int k;
        logic [N-1:0] rp;
        logic         re;

        rst_n      = 1'b0;
        enable     = 1'b0;
        pattern_in = '0;
        model_reset();
        #12;
        check("rst_led", {24'b0, led_out}, 32'h0);
        check("rst_wrap", {31'b0, pwm_wrap}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;

        // Idle pattern: dark, never busy, wrap every 8 cycles.
        for (int c = 0; c < 40; c++) begin
            step(8'h00, 1'b1);
            check("idle_dark", {24'b0, led_out}, 32'h0);
        end

        // Full ramp of channel 0 and back down.
        for (int c = 0; c < 80; c++) step(8'h01, 1'b1);
        check("ch0_full", {24'b0, led_out}, 32'h1);
        for (int c = 0; c < 80; c++) step(8'h00, 1'b1);

        // Ramp to level 3 then reverse.
        k = 0;
        while (m_lvl[0] != 3 && k < 100) begin
            step(8'h01, 1'b1);
            k++;
        end
        check("reach_lvl3", k < 100, 1'b1);
        for (int c = 0; c < 40; c++) step(8'h00, 1'b1);

        // Freeze mid-ramp at level 4, then resume.
        k = 0;
        while (m_lvl[0] != 4 && k < 100) begin
            step(8'h01, 1'b1);
            k++;
        end
        check("reach_lvl4", k < 100, 1'b1);
        step(8'h01, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(8'h01, 1'b0);
            check("frozen_dark", {24'b0, led_out}, 32'h0);
        end
        for (int c = 0; c < 60; c++) step(8'h01, 1'b1);

        // Async reset mid-cycle during an all-channel ramp.
        for (int c = 0; c < 23; c++) step(8'hFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", {24'b0, led_out}, 32'h0);
        check("arst_wrap", {31'b0, pwm_wrap}, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        model_reset();
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) step(8'hFF, 1'b1);

        // Random patterns and enable gaps.
        hold = 0;
        rp   = '0;
        re   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                rp   = 8'($urandom);
                re   = ($urandom_range(0, 9) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            step(rp, re);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
